// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared sizes and element types for the output-stationary systolic array
package sa_pkg;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int AW = 32;

  typedef logic [DW-1:0] elem_t;
  typedef logic [AW-1:0] acc_t;
endpackage

// File: rtl/sa_out_array_if.sv
// rtl/sa_out_array_if.sv - edge streams, row-read select and readout bus of the systolic array
interface sa_out_array_if;
  import sa_pkg::*;

  logic            SA_fire_in;
  logic [N*DW-1:0] SA_data_in;
  logic [N*DW-1:0] SA_weight_in;
  logic [N-1:0]    CEN;
  logic            SA_fire_out;
  logic [N*DW-1:0] SA_data_out;
  logic [N*DW-1:0] SA_weight_out;
  logic [N*AW-1:0] Q;

  modport master (
    output SA_fire_in, SA_data_in, SA_weight_in, CEN,
    input  SA_fire_out, SA_data_out, SA_weight_out, Q
  );

  modport slave (
    input  SA_fire_in, SA_data_in, SA_weight_in, CEN,
    output SA_fire_out, SA_data_out, SA_weight_out, Q
  );
endinterface

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - one MAC cell: registers the passing operands and fire token, accumulates while fire is high
module sa_pe
  import sa_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  elem_t a_in,
  input  elem_t b_in,
  input  logic  f_in,
  output elem_t a_out,
  output elem_t b_out,
  output logic  f_out,
  output acc_t  acc
);
  logic [2*DW-1:0] prod;
  acc_t            prod_ext;

  assign prod     = a_in * b_in;
  assign prod_ext = {{(AW-2*DW){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      f_out <= 1'b0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      f_out <= f_in;
      // A rising fire edge (f_out still low) begins a new burst and drops the old sum.
      if (f_in)
        acc <= (f_out ? acc : '0) + prod_ext;
    end
  end
endmodule

// File: rtl/sa_out_array.sv
// rtl/sa_out_array.sv - 16x16 output-stationary systolic array with edge forwarding and CEN row readout
module sa_out_array
  import sa_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  sa_out_array_if.slave  bus
);
  elem_t a_q   [N][N];
  elem_t b_q   [N][N];
  logic  f_q   [N][N];
  acc_t  acc_q [N][N];

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      elem_t a_in;
      elem_t b_in;
      logic  f_in;

      if (j == 0) begin : g_a_edge
        assign a_in = bus.SA_data_in[i*DW +: DW];
      end else begin : g_a_int
        assign a_in = a_q[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = bus.SA_weight_in[j*DW +: DW];
      end else begin : g_b_int
        assign b_in = b_q[i-1][j];
      end

      // Fire travels right along each row, and down only the first column.
      if (i == 0 && j == 0) begin : g_f_src
        assign f_in = bus.SA_fire_in;
      end else if (j > 0) begin : g_f_left
        assign f_in = f_q[i][j-1];
      end else begin : g_f_up
        assign f_in = f_q[i-1][0];
      end

      sa_pe u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .a_in  (a_in),
        .b_in  (b_in),
        .f_in  (f_in),
        .a_out (a_q[i][j]),
        .b_out (b_q[i][j]),
        .f_out (f_q[i][j]),
        .acc   (acc_q[i][j])
      );
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_edge
    assign bus.SA_data_out[k*DW +: DW]   = a_q[k][N-1];
    assign bus.SA_weight_out[k*DW +: DW] = b_q[N-1][k];
  end

  assign bus.SA_fire_out = f_q[N-1][N-1];

  logic [N*AW-1:0] q_sel;

  // Scan from the top row down so the lowest selected row is written last and wins.
  always_comb begin
    q_sel = '0;
    for (int r = N-1; r >= 0; r--) begin
      if (!bus.CEN[r]) begin
        for (int c = 0; c < N; c++)
          q_sel[c*AW +: AW] = acc_q[r][c];
      end
    end
  end

  assign bus.Q = q_sel;
endmodule

// File: tb/tb_sa_out_array.sv
// tb/tb_sa_out_array.sv - scoreboard bench for sa_out_array
module tb_sa_out_array;
  import sa_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  sa_out_array_if bus ();

  sa_out_array dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam int K_Q    = 0;
  localparam int K_DATA = 1;
  localparam int K_WGT  = 2;
  localparam int K_FIRE = 3;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int kind, input int idx);
    case (kind)
      K_Q:     return bus.Q[idx*AW +: AW];
      K_DATA:  return {24'b0, bus.SA_data_out[idx*DW +: DW]};
      K_WGT:   return {24'b0, bus.SA_weight_out[idx*DW +: DW]};
      default: return {31'b0, bus.SA_fire_out};
    endcase
  endfunction

  task automatic sb_push(input string tag, input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic sb_drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s[%0d]", e.tag, e.idx), observe(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.SA_fire_in   = 1'b0;
    bus.SA_data_in   = '0;
    bus.SA_weight_in = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] exp_sum;
    logic [7:0]  v;
    longint      wrap_full;

    rst_n   = 1'b0;
    bus.CEN = '1;
    clear_inputs();
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset asserted mid-burst clears everything at once
    bus.CEN = '0;
    bus.SA_data_in   = {N{8'h11}};
    bus.SA_weight_in = {N{8'h22}};
    bus.SA_fire_in   = 1'b1;
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    sb_push("rst_async_q", K_Q, 0, 32'h0);
    sb_push("rst_async_data", K_DATA, 0, 32'h0);
    sb_push("rst_async_wgt", K_WGT, 0, 32'h0);
    sb_drain();
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < N; k++) begin
      sb_push("rst_data", K_DATA, k, 32'h0);
      sb_push("rst_wgt", K_WGT, k, 32'h0);
      sb_push("rst_q_cen0", K_Q, k, 32'h0);
    end
    sb_push("rst_fire", K_FIRE, 0, 32'h0);
    sb_drain();
    bus.CEN = '1;
    #1;
    for (int k = 0; k < N; k++) sb_push("rst_q_cen1", K_Q, k, 32'h0);
    sb_drain();

    // Single-PE burst on lane 0
    do_reset();
    bus.CEN = '0;
    exp_sum = '0;
    for (int k = 0; k < 17; k++) begin
      v = (k == 0) ? 8'h00 : 8'(8'hFF - (k - 1));
      bus.SA_data_in[7:0]   = v;
      bus.SA_weight_in[7:0] = v;
      bus.SA_fire_in        = 1'b1;
      exp_sum += 32'(v) * 32'(v);
      step();
    end
    clear_inputs();
    step();
    step();
    sb_push("burst_w0", K_Q, 0, exp_sum);
    check("burst_const", exp_sum, 32'h000EF5D8);
    for (int k = 1; k < N; k++) sb_push("burst_wn", K_Q, k, 32'h0);
    sb_drain();

    // Edge latencies
    do_reset();
    bus.SA_fire_in           = 1'b1;
    bus.SA_data_in[5*8 +: 8] = 8'hAB;
    bus.SA_weight_in[9*8 +: 8] = 8'h5C;
    for (int s = 1; s <= 32; s++) begin
      step();
      if (s == 1) clear_inputs();
      if (s >= 15 && s <= 17) begin
        sb_push($sformatf("lat_data_s%0d", s), K_DATA, 5, (s == 16) ? 32'hAB : 32'h0);
        sb_push($sformatf("lat_wgt_s%0d", s), K_WGT, 9, (s == 16) ? 32'h5C : 32'h0);
      end
      if (s >= 30) sb_push($sformatf("lat_fire_s%0d", s), K_FIRE, 0, (s == 31) ? 32'h1 : 32'h0);
      sb_drain();
    end

    // Restart after a one-cycle fire gap, progressing along the diagonal
    do_reset();
    bus.CEN = '0;
    bus.SA_data_in[7:0]    = 8'd3;
    bus.SA_weight_in[7:0]  = 8'd5;
    bus.SA_weight_in[15:8] = 8'd7;
    bus.SA_fire_in = 1'b1;
    repeat (4) step();
    bus.SA_fire_in = 1'b0;
    step();
    sb_push("rs_done", K_Q, 0, 32'(4 * 3 * 5));
    sb_push("rs_done", K_Q, 1, 32'(4 * 3 * 7));
    sb_drain();
    clear_inputs();
    bus.SA_fire_in = 1'b1;
    step();
    sb_push("rs_pe00", K_Q, 0, 32'h0);
    sb_push("rs_pe01_hold", K_Q, 1, 32'(4 * 3 * 7));
    sb_drain();
    step();
    sb_push("rs_pe00_b", K_Q, 0, 32'h0);
    sb_push("rs_pe01", K_Q, 1, 32'h0);
    sb_drain();
    clear_inputs();

    // Row select with priority to the lowest row
    do_reset();
    for (int k = 0; k < N; k++) begin
      bus.SA_data_in[k*8 +: 8]   = 8'(k + 1);
      bus.SA_weight_in[k*8 +: 8] = 8'(k + 2);
    end
    bus.SA_fire_in = 1'b1;
    step();
    bus.SA_fire_in = 1'b0;
    repeat (34) step();
    bus.CEN = 16'hFFF7;
    #1;
    for (int k = 0; k < N; k++) sb_push("row3", K_Q, k, 32'(4 * (k + 2)));
    sb_drain();
    bus.CEN = 16'hFFF6;
    #1;
    for (int k = 0; k < N; k++) sb_push("row0_prio", K_Q, k, 32'(k + 2));
    sb_drain();
    bus.CEN = 16'hFFFF;
    #1;
    for (int k = 0; k < N; k++) sb_push("row_none", K_Q, k, 32'h0);
    sb_drain();
    clear_inputs();

    // Accumulator wraps modulo 2^32
    do_reset();
    bus.CEN = '0;
    bus.SA_data_in[7:0]   = 8'hFF;
    bus.SA_weight_in[7:0] = 8'hFF;
    bus.SA_fire_in        = 1'b1;
    repeat (66052) step();
    wrap_full = longint'(255 * 255) * 66052;
    sb_push("wrap", K_Q, 0, wrap_full[31:0]);
    sb_drain();
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
